// File: rtl/gate_mux2_reg.sv
// 2:1 select cell built from AND/NOT/OR gate primitives, with a combinational
// output and an enabled, async-reset registered copy.

module gm_and2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module gm_inv (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

module gm_or2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

module gate_mux2_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] out_comb,
  output logic [WIDTH-1:0] out_q
);

  logic             sel_n;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] x2;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // One shared inverter drives the b-side AND of every bit.
  gm_inv u_inv (
    .a (sel),
    .y (sel_n)
  );

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    gm_and2 u_and_a (
      .a (a[i]),
      .b (sel),
      .y (x1[i])
    );
    gm_and2 u_and_b (
      .a (b[i]),
      .b (sel_n),
      .y (x2[i])
    );
    gm_or2 u_or (
      .a (x1[i]),
      .b (x2[i]),
      .y (out_comb[i])
    );
  end

  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = out_comb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign out_q = data_q;

endmodule

// File: tb/tb_gate_mux2_reg.sv
// Randomized and directed checks of gate_mux2_reg at WIDTH=1 and WIDTH=8
// against a simple select/load reference model.

module tb_gate_mux2_reg;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       sel;
  logic       a1, b1;
  logic [7:0] a8, b8;
  logic       comb1, q1;
  logic [7:0] comb8, q8;

  logic       exp1_q;
  logic [7:0] exp8_q;

  int checks;
  int errors;

  gate_mux2_reg #(.WIDTH(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .a        (a1),
    .b        (b1),
    .sel      (sel),
    .out_comb (comb1),
    .out_q    (q1)
  );

  gate_mux2_reg #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .a        (a8),
    .b        (b8),
    .sel      (sel),
    .out_comb (comb8),
    .out_q    (q8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_sel8(input logic s, input logic [7:0] x, input logic [7:0] y);
    return s ? x : y;
  endfunction

  // Combinational outputs must track the model without any clock edge.
  task automatic chk_comb(input string tag);
    #1;
    chk({tag, "_comb1"}, 64'(comb1), 64'(sel ? a1 : b1));
    chk({tag, "_comb8"}, 64'(comb8), 64'(ref_sel8(sel, a8, b8)));
  endtask

  // Advance one edge, update the model from pre-edge values, check out_q.
  task automatic tick(input string tag);
    logic       n1;
    logic [7:0] n8;
    n1 = exp1_q;
    n8 = exp8_q;
    if (rst_n && en) begin
      n1 = sel ? a1 : b1;
      n8 = ref_sel8(sel, a8, b8);
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      n1 = 1'b0;
      n8 = 8'h00;
    end
    exp1_q = n1;
    exp8_q = n8;
    chk({tag, "_q1"}, 64'(q1), 64'(exp1_q));
    chk({tag, "_q8"}, 64'(q8), 64'(exp8_q));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp1_q = 1'b0;
    exp8_q = 8'h00;

    // Power-up under reset
    rst_n = 1'b0;
    en = 1'b1; sel = 1'b0;
    a1 = 1'b0; b1 = 1'b1;
    a8 = 8'h00; b8 = 8'hFF;
    #1;
    chk("pwr_comb1", 64'(comb1), 64'(1));
    chk("pwr_q1_rst", 64'(q1), 64'(0));
    tick("pwr_hold");
    tick("pwr_hold2");
    rst_n = 1'b1;
    tick("pwr_load");
    chk("pwr_q1_one", 64'(q1), 64'(1));

    // Select toggle
    a1 = 1'b1; b1 = 1'b0; sel = 1'b1;
    chk_comb("tog0");
    chk("tog0_lit", 64'(comb1), 64'(1));
    a1 = 1'b0; b1 = 1'b1;
    chk_comb("tog1");
    chk("tog1_lit", 64'(comb1), 64'(0));
    sel = 1'b0;
    chk_comb("tog2");
    chk("tog2_lit", 64'(comb1), 64'(1));

    // Exhaustive WIDTH=1 truth table with registered follow-up
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; sel = v[0];
      chk_comb("tt");
      tick("tt");
    end

    // Enable hold
    en = 1'b1; sel = 1'b1; a1 = 1'b1; a8 = 8'hFF;
    chk_comb("hold_ld");
    tick("hold_ld");
    chk("hold_q1_one", 64'(q1), 64'(1));
    en = 1'b0; a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      chk_comb("hold");
      tick("hold");
      chk("hold_q1_lit", 64'(q1), 64'(1));
    end
    en = 1'b1;
    tick("hold_rel");
    chk("hold_rel_lit", 64'(q1), 64'(0));

    // Async reset between edges
    a1 = 1'b1; a8 = 8'h5A;
    tick("ar_ld");
    chk("ar_q1_one", 64'(q1), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    exp1_q = 1'b0;
    exp8_q = 8'h00;
    chk("ar_q1", 64'(q1), 64'(0));
    chk("ar_q8", 64'(q8), 64'(0));
    chk("ar_comb1", 64'(comb1), 64'(1));
    chk("ar_comb8", 64'(comb8), 64'(8'h5A));
    rst_n = 1'b1;

    // WIDTH=8 pattern
    a8 = 8'hA5; b8 = 8'h3C; sel = 1'b1; en = 1'b1;
    chk_comb("w8s1");
    chk("w8s1_lit", 64'(comb8), 64'(8'hA5));
    tick("w8s1");
    sel = 1'b0;
    chk_comb("w8s0");
    chk("w8s0_lit", 64'(comb8), 64'(8'h3C));
    tick("w8s0");
    chk("w8s0_q_lit", 64'(q8), 64'(8'h3C));

    // Randomized stream
    for (int i = 0; i < 300; i++) begin
      a1  = 1'($urandom);
      b1  = 1'($urandom);
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      sel = 1'($urandom);
      en  = ($urandom_range(0, 3) != 0);
      chk_comb("rnd");
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
